// File: rtl/vmicro16_timer_multi_apb_pkg.sv
// Shared register map and control-field layout for the multi-channel APB timer.
package vmicro16_timer_multi_apb_pkg;

  // Channel bank register offsets (S_PADDR[1:0])
  localparam logic [1:0] TIMR_LOAD     = 2'd0;
  localparam logic [1:0] TIMR_COUNT    = 2'd1;
  localparam logic [1:0] TIMR_CTRL     = 2'd2;
  localparam logic [1:0] TIMR_PRES     = 2'd3;

  // Global bank register offsets (S_PADDR[1:0] with the bank bit set)
  localparam logic [1:0] TIMR_G_STATUS = 2'd0;
  localparam logic [1:0] TIMR_G_START  = 2'd1;

  // CTRL bit positions
  localparam int TIMR_CTRL_EN      = 0;
  localparam int TIMR_CTRL_ONESHOT = 1;
  localparam int TIMR_CTRL_IE      = 2;
  localparam int TIMR_CTRL_W       = 3;

  // CTRL register layout; first member is the MSB so en lands on bit 0
  typedef struct packed {
    logic ie;
    logic oneshot;
    logic en;
  } timr_ctrl_t;

endpackage

// File: rtl/vmicro16_timer_chan.sv
// One timer channel: LOAD/CTRL/PRES registers, prescaler, down-counter and expiry.
module vmicro16_timer_chan
  import vmicro16_timer_multi_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_load,
  input  logic                  wr_ctrl,
  input  logic                  wr_pres,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  expire,
  output timr_ctrl_t            ctrl,
  output logic [DATA_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] load,
  output logic [DATA_WIDTH-1:0] pres
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] pres_q, pres_d;
  logic [DATA_WIDTH-1:0] pres_cnt_q, pres_cnt_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  timr_ctrl_t            ctrl_q, ctrl_d;
  logic                  tick;

  // Next-state for registers, prescaler and counter; a LOAD write overrides any tick
  always_comb begin
    tick   = ctrl_q.en && (pres_cnt_q == '0);
    expire = tick && (count_q == '0) && !wr_load;

    load_d = wr_load ? wdata : load_q;
    pres_d = wr_pres ? wdata : pres_q;

    // One-shot expiry drops EN; an explicit CTRL write or START then has the last word
    ctrl_d = ctrl_q;
    if (expire && ctrl_q.oneshot) ctrl_d.en = 1'b0;
    if (wr_ctrl) ctrl_d = timr_ctrl_t'(wdata[TIMR_CTRL_W-1:0]);
    if (start) ctrl_d.en = 1'b1;

    // Prescaler holds while disabled; reload uses the PRES value in effect now
    pres_cnt_d = pres_cnt_q;
    if (ctrl_q.en) pres_cnt_d = tick ? pres_q : (pres_cnt_q - ONE);
    if (wr_load || (ctrl_d.en && !ctrl_q.en)) pres_cnt_d = pres_q;

    count_d = count_q;
    if (wr_load) count_d = wdata;
    else if (tick) count_d = (count_q == '0) ? load_q : (count_q - ONE);
  end

  // Channel state flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q     <= '0;
      pres_q     <= '0;
      pres_cnt_q <= '0;
      count_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      load_q     <= load_d;
      pres_q     <= pres_d;
      pres_cnt_q <= pres_cnt_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign count = count_q;
  assign load  = load_q;
  assign pres  = pres_q;

endmodule

// File: rtl/vmicro16_timer_multi_apb.sv
// APB slave wrapping CHANNELS timer channels with a shared W1C status register and irq.
module vmicro16_timer_multi_apb
  import vmicro16_timer_multi_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int CH_BITS    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH_BITS+2:0]    S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic [CHANNELS-1:0]   out,
  output logic                  irq
);

  logic               access, wr, bank_g;
  logic [CH_BITS-1:0] ch_idx;
  logic [1:0]         off;

  assign access = S_PSELx & S_PENABLE;
  assign wr     = access & S_PWRITE;
  assign bank_g = S_PADDR[CH_BITS+2];
  assign ch_idx = S_PADDR[CH_BITS+1:2];
  assign off    = S_PADDR[1:0];

  logic [CHANNELS-1:0]   expire_vec, en_vec, ie_vec;
  logic [CHANNELS-1:0]   status_q, status_d, clr_mask;
  timr_ctrl_t            ctrl_arr  [CHANNELS];
  logic [DATA_WIDTH-1:0] count_arr [CHANNELS];
  logic [DATA_WIDTH-1:0] load_arr  [CHANNELS];
  logic [DATA_WIDTH-1:0] pres_arr  [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic sel_ch;
    assign sel_ch = wr && !bank_g && (ch_idx == CH_BITS'(i));

    vmicro16_timer_chan #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .wr_load(sel_ch && (off == TIMR_LOAD)),
      .wr_ctrl(sel_ch && (off == TIMR_CTRL)),
      .wr_pres(sel_ch && (off == TIMR_PRES)),
      .start  (wr && bank_g && (off == TIMR_G_START) && S_PWDATA[i]),
      .wdata  (S_PWDATA),
      .expire (expire_vec[i]),
      .ctrl   (ctrl_arr[i]),
      .count  (count_arr[i]),
      .load   (load_arr[i]),
      .pres   (pres_arr[i])
    );

    assign en_vec[i] = ctrl_arr[i][TIMR_CTRL_EN];
    assign ie_vec[i] = ctrl_arr[i][TIMR_CTRL_IE];
  end

  // Sticky status: W1C clear, but a same-cycle expiry keeps the bit set
  always_comb begin
    clr_mask = '0;
    if (wr && bank_g && (off == TIMR_G_STATUS)) clr_mask = S_PWDATA[CHANNELS-1:0];
    status_d = (status_q & ~clr_mask) | expire_vec;
  end

  // Status register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) status_q <= '0;
    else        status_q <= status_d;
  end

  // Combinational read mux; zero outside the access phase
  always_comb begin
    S_PRDATA = '0;
    if (access) begin
      if (bank_g) begin
        case (off)
          TIMR_G_STATUS: S_PRDATA = DATA_WIDTH'(status_q);
          TIMR_G_START:  S_PRDATA = DATA_WIDTH'(en_vec);
          default:       S_PRDATA = '0;
        endcase
      end else begin
        case (off)
          TIMR_LOAD:  S_PRDATA = load_arr[ch_idx];
          TIMR_COUNT: S_PRDATA = count_arr[ch_idx];
          TIMR_CTRL:  S_PRDATA = DATA_WIDTH'(ctrl_arr[ch_idx]);
          default:    S_PRDATA = pres_arr[ch_idx];
        endcase
      end
    end
  end

  assign S_PREADY = access;
  assign out      = expire_vec;
  assign irq      = |(status_q & ie_vec);

endmodule

// File: tb/tb_vmicro16_timer_multi_apb.sv
// Directed bench for vmicro16_timer_multi_apb with a cycle-level reference model.
module tb_vmicro16_timer_multi_apb;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int CB = 2;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [CB+2:0] S_PADDR   = '0;
  logic          S_PWRITE  = 1'b0;
  logic          S_PSELx   = 1'b0;
  logic          S_PENABLE = 1'b0;
  logic [DW-1:0] S_PWDATA  = '0;
  logic [DW-1:0] S_PRDATA;
  logic          S_PREADY;
  logic [CH-1:0] out;
  logic          irq;

  vmicro16_timer_multi_apb #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .CH_BITS   (CB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .S_PADDR  (S_PADDR),
    .S_PWRITE (S_PWRITE),
    .S_PSELx  (S_PSELx),
    .S_PENABLE(S_PENABLE),
    .S_PWDATA (S_PWDATA),
    .S_PRDATA (S_PRDATA),
    .S_PREADY (S_PREADY),
    .out      (out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int n_chk   = 0;
  int n_fail  = 0;
  int last_wr = 0;
  int pq [CH][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (timer rules at channel level) ----------------
  int      m_load [CH];
  int      m_pres [CH];
  int      m_pcnt [CH];
  int      m_cnt  [CH];
  bit      m_en   [CH];
  bit      m_os   [CH];
  bit      m_ie   [CH];
  bit [3:0] m_status;

  function automatic bit m_expire(input int i);
    bit wl;
    wl = S_PSELx && S_PENABLE && S_PWRITE && !S_PADDR[4] &&
         (int'(S_PADDR[3:2]) == i) && (S_PADDR[1:0] == 2'd0);
    return m_en[i] && (m_pcnt[i] == 0) && (m_cnt[i] == 0) && !wl;
  endfunction

  function automatic logic [CH-1:0] m_out();
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++) e[i] = m_expire(i);
    return e;
  endfunction

  function automatic logic m_irq();
    logic r = 1'b0;
    for (int i = 0; i < CH; i++) r = r | (m_status[i] & m_ie[i]);
    return r;
  endfunction

  function automatic logic [DW-1:0] m_read();
    int c;
    logic [CH-1:0] env;
    c = int'(S_PADDR[3:2]);
    for (int i = 0; i < CH; i++) env[i] = m_en[i];
    if (!(S_PSELx && S_PENABLE)) return '0;
    if (S_PADDR[4]) begin
      if (S_PADDR[1:0] == 2'd0) return DW'(m_status);
      if (S_PADDR[1:0] == 2'd1) return DW'(env);
      return '0;
    end
    case (S_PADDR[1:0])
      2'd0:    return DW'(m_load[c]);
      2'd1:    return DW'(m_cnt[c]);
      2'd2:    return DW'({m_ie[c], m_os[c], m_en[c]});
      default: return DW'(m_pres[c]);
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_load[i] = 0; m_pres[i] = 0; m_pcnt[i] = 0; m_cnt[i] = 0;
      m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0;
    end
    m_status = '0;
  endtask

  task automatic m_step();
    bit w;
    bit g;
    int c;
    int o;
    int wd;
    bit [3:0] e;
    w  = S_PSELx && S_PENABLE && S_PWRITE;
    g  = S_PADDR[4];
    c  = int'(S_PADDR[3:2]);
    o  = int'(S_PADDR[1:0]);
    wd = int'(S_PWDATA);
    for (int i = 0; i < CH; i++) e[i] = m_expire(i);
    for (int i = 0; i < CH; i++) begin
      bit wl, wc, wp, st, tick, en_was;
      wl     = w && !g && (c == i) && (o == 0);
      wc     = w && !g && (c == i) && (o == 2);
      wp     = w && !g && (c == i) && (o == 3);
      st     = w && g && (o == 1) && S_PWDATA[i];
      tick   = m_en[i] && (m_pcnt[i] == 0);
      en_was = m_en[i];
      if (e[i] && m_os[i]) m_en[i] = 0;
      if (wc) begin
        m_en[i] = S_PWDATA[0]; m_os[i] = S_PWDATA[1]; m_ie[i] = S_PWDATA[2];
      end
      if (st) m_en[i] = 1;
      if (wl || (m_en[i] && !en_was)) m_pcnt[i] = m_pres[i];
      else if (en_was) m_pcnt[i] = tick ? m_pres[i] : m_pcnt[i] - 1;
      if (wl) m_cnt[i] = wd;
      else if (tick) m_cnt[i] = (m_cnt[i] == 0) ? m_load[i] : m_cnt[i] - 1;
      if (wl) m_load[i] = wd;
      if (wp) m_pres[i] = wd;
    end
    if (w && g && (o == 0)) m_status = m_status & ~S_PWDATA[3:0];
    m_status = m_status | e;
  endtask

  // Model advances on every clock edge, and clears at once on reset
  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else        m_step();
  end

  // Per-cycle comparison of all outputs against the model; also logs pulse edges
  always @(negedge clk) begin
    #2;
    chk("out",    32'(out),      32'(m_out()));
    chk("irq",    32'(irq),      32'(m_irq()));
    chk("pready", 32'(S_PREADY), 32'(S_PSELx && S_PENABLE));
    chk("prdata", 32'(S_PRDATA), 32'(m_read()));
    for (int i = 0; i < CH; i++) if (out[i]) pq[i].push_back(cyc + 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- APB helpers ----------------
  function automatic logic [CB+2:0] ca(input int c, input int o);
    logic [1:0] cc;
    logic [1:0] oo;
    cc = 2'(c);
    oo = 2'(o);
    return {1'b0, cc, oo};
  endfunction

  function automatic logic [CB+2:0] ga(input int o);
    logic [1:0] oo;
    oo = 2'(o);
    return {1'b1, 2'b00, oo};
  endfunction

  function automatic bit pulse_at(input int c, input int e_idx);
    for (int k = 0; k < pq[c].size(); k++) if (pq[c][k] == e_idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apb_write(input logic [CB+2:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = a; S_PWDATA = d;
    @(negedge clk);
    S_PENABLE = 1'b1;
    @(negedge clk);
    S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    last_wr = cyc;
  endtask

  task automatic apb_read(input logic [CB+2:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PADDR = a;
    #1 chk("pready_setup", 32'(S_PREADY), 32'd0);
    @(negedge clk);
    S_PENABLE = 1'b1;
    #1 chk("pready_access", 32'(S_PREADY), 32'd1);
    d = S_PRDATA;
    @(negedge clk);
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DW-1:0] rd;
    int c0;
    int cs;
    int cl;

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < 4; o++) begin
        apb_read(ca(c, o), rd);
        chk($sformatf("rst_ch%0d_reg%0d", c, o), 32'(rd), 32'd0);
      end
    for (int o = 0; o < 4; o++) begin
      apb_read(ga(o), rd);
      chk($sformatf("rst_glob%0d", o), 32'(rd), 32'd0);
    end

    // Periodic: ch0 PRES=1 LOAD=3 EN|IE -> pulse every 8 clocks
    apb_write(ca(0, 3), 16'd1);
    apb_write(ca(0, 0), 16'd3);
    pq[0].delete();
    apb_write(ca(0, 2), 16'h5);
    c0 = last_wr;
    while (cyc < c0 + 9) @(negedge clk);
    apb_read(ga(0), rd);
    chk("per_status", 32'(rd), 32'h1);
    #1 chk("per_irq_set", 32'(irq), 32'd1);
    apb_write(ga(0), 16'h1);
    #1 chk("per_irq_clr", 32'(irq), 32'd0);

    // One-shot: ch2 PRES=0 LOAD=2 EN|ONESHOT -> single pulse 3 clocks later
    apb_write(ca(2, 3), 16'd0);
    apb_write(ca(2, 0), 16'd2);
    pq[2].delete();
    apb_write(ca(2, 2), 16'h3);
    cs = last_wr;
    repeat (20) @(negedge clk);
    chk("os_pulses", 32'(pq[2].size()), 32'd1);
    if (pq[2].size() > 0) chk("os_delay", 32'(pq[2][0] - cs), 32'd3);
    apb_read(ca(2, 2), rd);
    chk("os_ctrl", 32'(rd), 32'h2);
    apb_read(ca(2, 1), rd);
    chk("os_count", 32'(rd), 32'd2);

    // Periodic repetition of ch0 observed over the whole window so far
    chk("per_npulses_ge3", 32'(pq[0].size() >= 3), 32'd1);
    if (pq[0].size() >= 3) begin
      chk("per_first",   32'(pq[0][0] - c0),       32'd8);
      chk("per_period1", 32'(pq[0][1] - pq[0][0]), 32'd8);
      chk("per_period2", 32'(pq[0][2] - pq[0][1]), 32'd8);
    end

    // Synchronised start of ch0 and ch1, LOAD=5 PRES=0
    apb_write(ca(0, 2), 16'h0);
    apb_write(ca(0, 3), 16'd0);
    apb_write(ca(0, 0), 16'd5);
    apb_write(ca(1, 3), 16'd0);
    apb_write(ca(1, 0), 16'd5);
    pq[0].delete();
    pq[1].delete();
    apb_write(ga(1), 16'h3);
    cs = last_wr;
    repeat (10) @(negedge clk);
    chk("start_ch0", (pq[0].size() > 0) ? 32'(pq[0][0] - cs) : 32'hFFFF_FFFF, 32'd6);
    chk("start_ch1", (pq[1].size() > 0) ? 32'(pq[1][0] - cs) : 32'hFFFF_FFFF, 32'd6);
    apb_read(ga(1), rd);
    chk("start_en", 32'(rd), 32'h3);

    // Collision: W1C on ch3 while it expires every clock -> bit stays set
    apb_write(ca(3, 3), 16'd0);
    apb_write(ca(3, 0), 16'd0);
    apb_write(ca(3, 2), 16'h5);
    repeat (2) @(negedge clk);
    apb_write(ga(0), 16'h8);
    apb_read(ga(0), rd);
    chk("w1c_vs_expire", 32'(rd[3]), 32'd1);

    // Collision: LOAD write on an expiry/tick cycle -> no pulse, COUNT takes new value
    apb_write(ca(3, 0), 16'd20);
    cl = last_wr;
    apb_read(ca(3, 1), rd);
    chk("load_count", 32'(rd), 32'd18);
    chk("load_nopulse", 32'(pulse_at(3, cl)), 32'd0);
    chk("load_prevpulse", 32'(pulse_at(3, cl - 1)), 32'd1);
    apb_write(ca(3, 2), 16'h0);
    apb_write(ga(0), 16'h8);
    apb_read(ga(0), rd);
    chk("status_cleared", 32'(rd[3]), 32'd0);

    // Async reset mid-count with irq high
    apb_write(ca(0, 2), 16'h5);
    repeat (8) @(negedge clk);
    #1 chk("ar_irq_before", 32'(irq), 32'd1);
    @(negedge clk);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PADDR = ca(0, 1);
    @(negedge clk);
    S_PENABLE = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("ar_irq",   32'(irq),      32'd0);
    chk("ar_out",   32'(out),      32'd0);
    chk("ar_count", 32'(S_PRDATA), 32'd0);
    @(negedge clk);
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
    pq[0].delete();
    pq[1].delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("ar_idle_ch0", 32'(pq[0].size()), 32'd0);
    chk("ar_idle_ch1", 32'(pq[1].size()), 32'd0);
    apb_read(ga(1), rd);
    chk("ar_en", 32'(rd), 32'd0);
    apb_read(ga(0), rd);
    chk("ar_status", 32'(rd), 32'd0);
    apb_read(ca(0, 1), rd);
    chk("ar_count_after", 32'(rd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
